// File: rtl/neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// neuron_mac_unit
//
// Purpose:
//   Single-neuron datapath stage that sits behind the accelerator sequencer.
//   A load_mat strobe captures one input vector, one weight vector and a
//   bias. A computation strobe then runs a serial multiply-accumulate over
//   the N element pairs, one pair per clock. The bias is added, the sum is
//   passed through ReLU with unsigned saturation, and the result is
//   presented as a registered output with a one-cycle valid strobe.
//
// Parameters:
//   N   - vector length (elements per neuron), >= 1
//   DW  - signed width of each input, weight and the bias
//   AW  - signed accumulator width, at least 2*DW + clog2(N) + 1 so the
//         accumulator can never overflow
//   OW  - unsigned output width
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   load_mat     one-cycle strobe: capture x_in, w_in, bias_in (IDLE only)
//   computation  one-cycle strobe: start the MAC sequence (IDLE only)
//   x_in         packed signed inputs, element i at [i*DW +: DW]
//   w_in         packed signed weights, same packing as x_in
//   bias_in      signed bias
//   y_out        unsigned ReLU/saturated result, held until the next result
//   y_valid      one-cycle strobe: y_out was updated at the last edge
//   mac_busy     high while a MAC sequence is in progress
// ---------------------------------------------------------------------------
module neuron_mac_unit #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int OW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_mat,
  input  logic            computation,
  input  logic [N*DW-1:0] x_in,
  input  logic [N*DW-1:0] w_in,
  input  logic [DW-1:0]   bias_in,
  output logic [OW-1:0]   y_out,
  output logic            y_valid,
  output logic            mac_busy
);

  // Element index width; a single-element neuron still needs one bit.
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Largest value representable on the unsigned output, widened to the
  // accumulator so the saturation compare is done at full precision.
  localparam logic [AW-1:0] SAT_MAX = {{(AW-OW){1'b0}}, {OW{1'b1}}};

  // Index value of the final element; the MAC phase ends after it.
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    BIAS,
    OUT
  } state_t;

  state_t state;

  logic signed [DW-1:0]   x_reg [N];
  logic signed [DW-1:0]   w_reg [N];
  logic signed [DW-1:0]   bias_reg;
  logic signed [AW-1:0]   acc;
  logic        [IW-1:0]   idx;

  logic signed [2*DW-1:0] product;
  logic signed [AW-1:0]   product_ext;
  logic signed [AW-1:0]   bias_ext;
  logic        [OW-1:0]   relu_sat;

  // Product of the currently selected element pair, then sign-extended
  // to the accumulator width. The operand registers are signed, so the
  // multiply is a true two's-complement multiply.
  always_comb begin
    product     = x_reg[idx] * w_reg[idx];
    product_ext = {{(AW-2*DW){product[2*DW-1]}}, product};
    bias_ext    = {{(AW-DW){bias_reg[DW-1]}}, bias_reg};
  end

  // ReLU followed by unsigned saturation. A set sign bit means the sum is
  // negative and clamps to zero; otherwise the magnitude is compared with
  // the output ceiling. The accumulator is known non-negative in that
  // branch, so an unsigned compare is exact.
  always_comb begin
    relu_sat = '0;
    if (acc[AW-1]) begin
      relu_sat = '0;
    end else if ($unsigned(acc) > SAT_MAX) begin
      relu_sat = '1;
    end else begin
      relu_sat = acc[OW-1:0];
    end
  end

  // Sequencer and datapath registers.
  // IDLE accepts operand loads and start requests; both may arrive on the
  // same edge, and the MAC then runs on the operands captured at that edge
  // because the first multiply happens one cycle later. MAC walks the
  // element pairs, BIAS folds in the bias, and OUT registers the
  // ReLU/saturated result. Strobes arriving while busy are dropped, which
  // keeps the operand registers stable for the whole sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      bias_reg <= '0;
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        w_reg[i] <= '0;
      end
      y_out    <= '0;
      y_valid  <= 1'b0;
      mac_busy <= 1'b0;
    end else begin
      y_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (load_mat) begin
            for (int i = 0; i < N; i++) begin
              x_reg[i] <= x_in[i*DW +: DW];
              w_reg[i] <= w_in[i*DW +: DW];
            end
            bias_reg <= bias_in;
          end
          if (computation) begin
            acc      <= '0;
            idx      <= '0;
            mac_busy <= 1'b1;
            state    <= MAC;
          end
        end

        MAC: begin
          acc <= acc + product_ext;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= BIAS;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        BIAS: begin
          acc   <= acc + bias_ext;
          state <= OUT;
        end

        OUT: begin
          y_out    <= relu_sat;
          y_valid  <= 1'b1;
          mac_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          mac_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_unit
//
// Purpose:
//   Self-checking bench for neuron_mac_unit. Operands are driven as plain
//   integer arrays; the expected neuron output is a dot product plus bias,
//   clamped to the unsigned output range. The bench keeps its own copy of
//   the operands the unit should currently hold, updated only when a load
//   is issued from idle and cleared on reset.
// ---------------------------------------------------------------------------
module tb_neuron_mac_unit;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int LATENCY = N + 2;
  localparam int OUT_MAX = (1 << OW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_mat;
  logic            computation;
  logic [N*DW-1:0] x_in;
  logic [N*DW-1:0] w_in;
  logic [DW-1:0]   bias_in;
  logic [OW-1:0]   y_out;
  logic            y_valid;
  logic            mac_busy;

  int assertCount = 0;
  int failCount   = 0;

  // Operands the unit is expected to hold right now.
  int mx [N];
  int mw [N];
  int mb;

  neuron_mac_unit #(
    .N (N),
    .DW(DW),
    .AW(AW),
    .OW(OW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_mat   (load_mat),
    .computation(computation),
    .x_in       (x_in),
    .w_in       (w_in),
    .bias_in    (bias_in),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .mac_busy   (mac_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected neuron output: dot product plus bias, then ReLU and clamp.
  function automatic int refNeuron();
    int s;
    s = mb;
    for (int i = 0; i < N; i++) s += mx[i] * mw[i];
    if (s < 0) return 0;
    if (s > OUT_MAX) return OUT_MAX;
    return s;
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive operands and strobes for one edge from idle, then drop strobes.
  task automatic applyStimulus(input int xs [N], input int ws [N],
                               input int b, input logic doLoad,
                               input logic doComp);
    for (int i = 0; i < N; i++) begin
      x_in[i*DW +: DW] = xs[i][DW-1:0];
      w_in[i*DW +: DW] = ws[i][DW-1:0];
    end
    bias_in     = b[DW-1:0];
    load_mat    = doLoad;
    computation = doComp;
    if (doLoad) begin
      mx = xs;
      mw = ws;
      mb = b;
    end
    tick();
    load_mat    = 1'b0;
    computation = 1'b0;
  endtask

  // Called just after the edge that sampled computation. Watches the busy
  // window, then checks the valid pulse and result. When injectAt >= 0 a
  // load of nines plus a second start is driven during that busy cycle.
  task automatic runCompute(input string tag, input int expY,
                            input int injectAt);
    int busySeen;
    int validEarly;
    busySeen   = 0;
    validEarly = 0;
    for (int c = 0; c < LATENCY; c++) begin
      if (mac_busy === 1'b1) busySeen++;
      if (y_valid !== 1'b0) validEarly++;
      if (c == injectAt) begin
        for (int i = 0; i < N; i++) x_in[i*DW +: DW] = 8'd9;
        load_mat    = 1'b1;
        computation = 1'b1;
      end
      tick();
      load_mat    = 1'b0;
      computation = 1'b0;
    end
    checkOutput({tag, " busy_cycles"}, busySeen, LATENCY);
    checkOutput({tag, " early_valid"}, validEarly, 0);
    checkOutput({tag, " y_valid"}, y_valid, 1);
    checkOutput({tag, " busy_at_valid"}, mac_busy, 0);
    checkOutput({tag, " y_out"}, y_out, expY);
    tick();
    checkOutput({tag, " valid_drop"}, y_valid, 0);
    checkOutput({tag, " y_out_hold"}, y_out, expY);
  endtask

  initial begin
    int basicX [N];
    int basicW [N];
    int rx [N];
    int rw [N];
    int rb;
    int extraValid;

    basicX = '{1, 2, 3, 4};
    basicW = '{5, 6, 7, 8};

    reset       = 1'b1;
    load_mat    = 1'b0;
    computation = 1'b0;
    x_in        = '0;
    w_in        = '0;
    bias_in     = '0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
    mb = 0;

    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset y_out", y_out, 0);
    checkOutput("reset y_valid", y_valid, 0);
    checkOutput("reset mac_busy", mac_busy, 0);

    // Start with nothing loaded: zero operands give zero.
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("noload", 0, -1);

    // Load, then start on the following cycle.
    applyStimulus(basicX, basicW, 10, 1'b1, 1'b0);
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("basic", refNeuron(), -1);
    checkOutput("basic ref", refNeuron(), 80);

    applyStimulus(basicX, '{-5, -6, -7, -8}, 10, 1'b1, 1'b0);
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("relu", 0, -1);

    applyStimulus('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0, 1'b1, 1'b1);
    runCompute("sat_pos", 255, -1);

    applyStimulus('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 127,
                  1'b1, 1'b1);
    runCompute("sat_negneg", 255, -1);

    applyStimulus('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 0,
                  1'b1, 1'b1);
    runCompute("neg_extreme", 0, -1);

    // Load and start on the same idle edge.
    applyStimulus(basicX, basicW, 10, 1'b1, 1'b1);
    runCompute("same_cycle", 80, -1);

    // Loads and starts during the busy window must be ignored.
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("busy_protect", 80, 1);
    extraValid = 0;
    for (int c = 0; c < 10; c++) begin
      if (y_valid !== 1'b0) extraValid++;
      tick();
    end
    checkOutput("busy_protect extra_valid", extraValid, 0);
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("busy_again", 80, -1);

    // Back-to-back start in the valid cycle is accepted.
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    for (int c = 0; c < LATENCY; c++) tick();
    checkOutput("b2b first_valid", y_valid, 1);
    computation = 1'b1;
    tick();
    computation = 1'b0;
    runCompute("b2b second", 80, -1);

    // Random operands, randomly loaded alone or together with the start.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        rx[i] = int'($urandom_range(255)) - 128;
        rw[i] = int'($urandom_range(255)) - 128;
      end
      rb = int'($urandom_range(255)) - 128;
      if ($urandom_range(1) == 1) begin
        applyStimulus(rx, rw, rb, 1'b1, 1'b1);
      end else begin
        applyStimulus(rx, rw, rb, 1'b1, 1'b0);
        applyStimulus(rx, rw, rb, 1'b0, 1'b1);
      end
      runCompute($sformatf("rand%0d", t), refNeuron(), -1);
    end

    // Reset in the middle of the MAC phase aborts the sequence.
    applyStimulus(basicX, basicW, 10, 1'b1, 1'b1);
    runCompute("pre_reset", 80, -1);
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
    mb = 0;
    checkOutput("midreset mac_busy", mac_busy, 0);
    checkOutput("midreset y_out", y_out, 0);
    extraValid = 0;
    for (int c = 0; c < 10; c++) begin
      if (y_valid !== 1'b0) extraValid++;
      tick();
    end
    checkOutput("midreset no_valid", extraValid, 0);
    applyStimulus(basicX, basicW, 10, 1'b0, 1'b1);
    runCompute("post_reset", refNeuron(), -1);
    checkOutput("post_reset ref", refNeuron(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
